// File: rtl/hazard_ctrl_pkg.sv
// Shared core definitions for hazard control.
// Used by hazard, forward and decode logic.
package hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: EX load whose rd is read by ID.
// x0 never creates a dependency.
module hazard_detect #(
    parameter int REG_ADDR_W = hazard_ctrl_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  load_use
);

    logic hit1;
    logic hit2;

    assign hit1 = id_use_rs1 && (id_rs1 == ex_rd);
    assign hit2 = id_use_rs2 && (id_rs2 == ex_rd);

    assign load_use = ex_mem_read && (ex_rd != '0) && (hit1 || hit2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles,
// branch flushes and data-memory freeze with timeout.
module hazard_ctrl #(
    parameter int REG_ADDR_W  = hazard_ctrl_pkg::REG_ADDR_W,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  idex_en,
    output logic                  idex_flush,
    output logic                  exmem_en,
    output logic                  mem_timeout_err,
    output logic [CNT_W-1:0]      stall_cycles
);

    import hazard_ctrl_pkg::*;

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] TMO = WC_W'(MEM_TIMEOUT);
    localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hz_state_e       state;
    hz_state_e       state_n;
    logic [WC_W-1:0] wait_cnt;
    logic [WC_W-1:0] wait_n;
    logic            err_n;
    logic            load_use;
    logic            mem_stall;

    hazard_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_mem_read(ex_mem_read),
        .load_use   (load_use)
    );

    // mem_req dropping counts as completion
    assign mem_stall = mem_req && !mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            wait_cnt        <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            state           <= state_n;
            wait_cnt        <= wait_n;
            mem_timeout_err <= err_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (!pc_en && stall_cycles != CNT_MAX) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        wait_n     = wait_cnt;
        err_n      = mem_timeout_err;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exmem_en   = 1'b1;

        unique case (state)
            RUN, MEM_WAIT: begin
                if (mem_stall) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    if (state == RUN) begin
                        state_n = MEM_WAIT;
                        wait_n  = WC_ONE;
                    end else if (wait_cnt == TMO) begin
                        state_n = ERROR;
                        err_n   = 1'b1;
                    end else begin
                        wait_n = wait_cnt + WC_ONE;
                    end
                end else begin
                    state_n = RUN;
                    wait_n  = '0;
                    // wrong-path ID instruction: skip load-use
                    if (ex_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
            end
            ERROR: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
            end
            default: begin
                state_n = RUN;
                wait_n  = '0;
            end
        endcase

        if (!rst_n) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b0;
            idex_en    = 1'b0;
            idex_flush = 1'b0;
            exmem_en   = 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a cycle model
// of the stall/flush rules and literal spot checks.
module tb_hazard_ctrl;

    localparam int RW  = 5;
    localparam int TMO = 15;
    localparam int CW  = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [RW-1:0] id_rs1 = '0;
    logic [RW-1:0] id_rs2 = '0;
    logic          id_use_rs1 = 1'b0;
    logic          id_use_rs2 = 1'b0;
    logic [RW-1:0] ex_rd = '0;
    logic          ex_mem_read = 1'b0;
    logic          ex_branch_taken = 1'b0;
    logic          mem_req = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_en;
    logic          ifid_en;
    logic          ifid_flush;
    logic          idex_en;
    logic          idex_flush;
    logic          exmem_en;
    logic          mem_timeout_err;
    logic [CW-1:0] stall_cycles;

    hazard_ctrl #(
        .REG_ADDR_W (RW),
        .MEM_TIMEOUT(TMO),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .ex_rd          (ex_rd),
        .ex_mem_read    (ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .ifid_flush     (ifid_flush),
        .idex_en        (idex_en),
        .idex_flush     (idex_flush),
        .exmem_en       (exmem_en),
        .mem_timeout_err(mem_timeout_err),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0 running, 1 waiting on memory, 2 dead.
    int m_mode = 0;
    int m_waited = 0;
    int m_err = 0;
    int m_cnt = 0;
    int n_mode, n_waited, n_err;
    int s_pc = 1;
    bit nxt_ok = 0;

    always @(negedge clk) begin
        bit lu, st, frz;
        int e_pc, e_ifid, e_ifidf, e_idex, e_idexf, e_exm;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) ||
              (id_use_rs2 && id_rs2 == ex_rd));
        st = mem_req && !mem_ready;
        n_mode = m_mode;
        n_waited = m_waited;
        n_err = m_err;
        frz = 0;
        e_pc = 1; e_ifid = 1; e_ifidf = 0;
        e_idex = 1; e_idexf = 0; e_exm = 1;
        if (m_mode == 2) begin
            frz = 1;
        end else if (st) begin
            frz = 1;
            if (m_mode == 0) begin
                n_mode = 1;
                n_waited = 1;
            end else if (m_waited >= TMO) begin
                n_mode = 2;
                n_err = 1;
            end else begin
                n_waited = m_waited + 1;
            end
        end else begin
            n_mode = 0;
            n_waited = 0;
            if (ex_branch_taken) begin
                e_ifidf = 1;
                e_idexf = 1;
            end else if (lu) begin
                e_pc = 0;
                e_ifid = 0;
                e_idexf = 1;
            end
        end
        if (frz) begin
            e_pc = 0; e_ifid = 0; e_idex = 0; e_exm = 0;
        end
        if (!rst_n) begin
            e_pc = 0; e_ifid = 0; e_ifidf = 0;
            e_idex = 0; e_idexf = 0; e_exm = 0;
        end
        chk("pc_en", int'(pc_en), e_pc);
        chk("ifid_en", int'(ifid_en), e_ifid);
        chk("ifid_flush", int'(ifid_flush), e_ifidf);
        chk("idex_en", int'(idex_en), e_idex);
        chk("idex_flush", int'(idex_flush), e_idexf);
        chk("exmem_en", int'(exmem_en), e_exm);
        chk("timeout_err", int'(mem_timeout_err), m_err);
        chk("stall_cycles", int'(stall_cycles), m_cnt);
        s_pc = e_pc;
        nxt_ok = rst_n;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0;
            m_waited = 0;
            m_err = 0;
            m_cnt = 0;
            nxt_ok = 0;
        end else if (nxt_ok) begin
            m_mode = n_mode;
            m_waited = n_waited;
            m_err = n_err;
            if (s_pc == 0 && m_cnt < CMAX) m_cnt++;
            nxt_ok = 0;
        end
    end

    task automatic drv(input bit ldr, input int rd,
                       input int rs1, input bit u1,
                       input int rs2, input bit u2,
                       input bit br, input bit mq, input bit mr);
        ex_mem_read = ldr;
        ex_rd = RW'(rd);
        id_rs1 = RW'(rs1);
        id_use_rs1 = u1;
        id_rs2 = RW'(rs2);
        id_use_rs2 = u2;
        ex_branch_taken = br;
        mem_req = mq;
        mem_ready = mr;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst pc_en", int'(pc_en), 0);
        chk("rst stall", int'(stall_cycles), 0);
        #1 rst_n = 1'b1;
        #1 chk("post rst pc_en", int'(pc_en), 1);

        // load-use bubble
        step();
        drv(1, 5, 5, 1, 0, 0, 0, 0, 0);
        #1;
        chk("lu pc_en", int'(pc_en), 0);
        chk("lu ifid_en", int'(ifid_en), 0);
        chk("lu idex_flush", int'(idex_flush), 1);
        step();
        idle();
        #1;
        chk("lu after pc_en", int'(pc_en), 1);
        chk("lu stall", int'(stall_cycles), 1);

        // x0 and unused operand, then a real rs2 hit
        drv(1, 0, 0, 1, 0, 1, 0, 0, 0);
        #1 chk("x0 pc_en", int'(pc_en), 1);
        step();
        drv(1, 7, 3, 1, 7, 0, 0, 0, 0);
        #1 chk("unused rs2 pc_en", int'(pc_en), 1);
        step();
        drv(1, 7, 3, 1, 7, 1, 0, 0, 0);
        #1 chk("rs2 hit pc_en", int'(pc_en), 0);
        step();
        idle();
        #1 chk("rs2 stall", int'(stall_cycles), 2);

        // branch beats load-use
        drv(1, 5, 5, 1, 0, 0, 1, 0, 0);
        #1;
        chk("br ifid_flush", int'(ifid_flush), 1);
        chk("br idex_flush", int'(idex_flush), 1);
        chk("br pc_en", int'(pc_en), 1);
        step();
        idle();
        #1 chk("br stall", int'(stall_cycles), 2);

        // three-cycle memory wait
        drv(0, 0, 0, 0, 0, 0, 1, 1, 0);
        #1 chk("mw exmem_en", int'(exmem_en), 0);
        repeat (3) @(posedge clk);
        #1 drv(0, 0, 0, 0, 0, 0, 0, 1, 1);
        #1 chk("mw release pc_en", int'(pc_en), 1);
        step();
        idle();
        #1 chk("mw stall", int'(stall_cycles), 5);

        // mem_req drop completes, load-use then applies
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        drv(1, 5, 5, 1, 0, 0, 0, 0, 0);
        #1;
        chk("drop exmem_en", int'(exmem_en), 1);
        chk("drop idex_flush", int'(idex_flush), 1);
        step();
        idle();
        #1 chk("drop stall", int'(stall_cycles), 7);

        // async reset in the middle of a wait
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst pc_en", int'(pc_en), 0);
        chk("arst exmem_en", int'(exmem_en), 0);
        chk("arst stall", int'(stall_cycles), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle();
        #1 chk("arst after pc_en", int'(pc_en), 1);

        // timeout and sticky error
        step();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (TMO) @(posedge clk);
        #1 chk("tmo not yet", int'(mem_timeout_err), 0);
        step();
        chk("tmo err", int'(mem_timeout_err), 1);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("err frozen pc_en", int'(pc_en), 0);
        chk("err sticky", int'(mem_timeout_err), 1);
        chk("stall sat", int'(stall_cycles), CMAX);
        #1 rst_n = 1'b0;
        #1;
        chk("err cleared", int'(mem_timeout_err), 0);
        chk("err stall clr", int'(stall_cycles), 0);
        rst_n = 1'b1;
        idle();
        #1 chk("err reset pc_en", int'(pc_en), 1);
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the in-order RV32I core.
- Complements the MEM→EX forwarding unit. It handles the hazards forwarding cannot cover:
  - load-use (bubble insertion),
  - taken-branch redirect (flush),
  - data-memory wait states (whole-pipe freeze, with timeout).
- Drives the pipeline-register enables and flushes, and keeps a stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 5, register index width.
- MEM_TIMEOUT, 15, maximum consecutive MEM_WAIT cycles before error (≥1).
- CNT_W, 16, stall performance counter width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1  in  REG_ADDR_W  rs1 of the instruction in ID.
- id_rs2  in  REG_ADDR_W  rs2 of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REG_ADDR_W  destination of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mem_req  in  1  MEM stage has an active load/store.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID clears to NOP.
- idex_en  out  1  ID/EX register enable.
- idex_flush  out  1  ID/EX clears to NOP (bubble).
- exmem_en  out  1  EX/MEM and MEM/WB register enable.
- mem_timeout_err  out  1  sticky memory-timeout error.
- stall_cycles  out  CNT_W  count of cycles with pc_en=0.

Behaviour:
Reset (rst_n=0, asynchronous):
- state=RUN; wait_cnt=0; mem_timeout_err=0; stall_cycles=0.
- While in reset, all enables and flushes are forced to 0.

Definitions:
- load_use = ex_mem_read & (ex_rd≠0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- mem_stall = mem_req & ~mem_ready.

Outputs are Mealy, combinational from state and inputs, with zero-cycle latency. Defaults: all enables 1, all flushes 0.

FSM states: RUN, MEM_WAIT, ERROR.

RUN, priority highest first:
1. mem_stall: freeze, i.e. pc_en = ifid_en = idex_en = exmem_en = 0, no flushes. Next state MEM_WAIT, wait_cnt=1. Any branch or load-use is ignored this cycle; it is re-evaluated after the freeze.
2. ex_branch_taken: ifid_flush=1 and idex_flush=1. The PC takes the target (pc_en=1). The load-use check is suppressed because the ID instruction is wrong-path.
3. load_use: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1. Exactly one bubble results, because the load moves to MEM next cycle and the forwarding unit covers it from there.

MEM_WAIT:
- mem_ready=1: outputs return to defaults (priorities 2 and 3 apply as in RUN); next state RUN; wait_cnt=0.
- else freeze; wait_cnt+1.
- When wait_cnt==MEM_TIMEOUT and still not ready: next state ERROR, mem_timeout_err←1.

ERROR:
- Pipeline frozen; all flushes 0; mem_timeout_err=1.
- Leaves only via rst_n. Late mem_ready is ignored.

mem_req deasserting in MEM_WAIT is treated as completion, equivalent to mem_ready.

stall_cycles:
- +1 on each clock edge where pc_en=0 while out of reset.
- Saturates at all-ones.
- Includes load-use, MEM_WAIT and ERROR cycles.

Simultaneous events follow the RUN priority order. Reset asserted mid-MEM_WAIT clears everything immediately.

Decomposition:
- Shared core package holds hz_state_e {RUN, MEM_WAIT, ERROR} and the REG_ADDR_W constant, reused by forward and decode.
- Natural sub-module: hazard_detect, the combinational load_use comparator. The FSM, wait counter and perf counter stay in hazard_ctrl.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → one cycle of pc_en=0, ifid_en=0, idex_flush=1; next cycle all defaults; stall_cycles=1.
2. x0 / unused operand: ex_rd=0 with id_rs1=0, or id_use_rs2=0 with id_rs2==ex_rd → no stall.
3. Branch plus load-use in the same cycle: ex_branch_taken=1 and load_use=1 → ifid_flush=1, idex_flush=1, pc_en=1; stall_cycles unchanged.
4. Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 → 3 frozen cycles (all enables 0), release on the 4th; stall_cycles=3; state RUN.
5. Timeout: mem_req=1, mem_ready held 0 → after MEM_TIMEOUT=15 wait cycles mem_timeout_err=1 and remains frozen through a later mem_ready=1; rst_n pulse clears it to RUN.
6. Async reset asserted mid-MEM_WAIT without a clock edge → outputs go to 0 and stall_cycles=0 immediately; after release, defaults (pc_en=1).
